// File: rtl/fetch_sched_if.sv
// Bus bundle between fetch_sched, the weight memory read port and the PE FIFO write ports.
interface fetch_sched_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic [NUM_CH-1:0] full;
  logic              fetch_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem_data;
  logic [NUM_CH-1:0] wr_en;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              all_done;

  modport master (
    input  start, base_addr, len, full, mem_data,
    output fetch_en, addr, wr_en, data_out, busy, all_done
  );

  modport slave (
    output start, base_addr, len, full, mem_data,
    input  fetch_en, addr, wr_en, data_out, busy, all_done
  );
endinterface

// File: rtl/fetch_sched.sv
// Round-robin fetch scheduler: banked weight memory reads into per-channel PE FIFO writes.
// Grants are decided one cycle ahead of the registered fetch_en; writes land MEM_LAT cycles after it.
module fetch_sched #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  fetch_sched_if.master bus
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q, len_q;
  logic [ADDR_W-1:0] idx_q [NUM_CH];
  logic [NUM_CH-1:0] inflight_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [NUM_CH-1:0] pipe_q [MEM_LAT];

  logic              accept;
  logic [ADDR_W-1:0] base_eff, len_eff, idx_eff;
  logic [PTR_W-1:0]  ptr_eff;
  logic [NUM_CH-1:0] elig, gnt;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_ch;
  logic [ADDR_W+3:0] prod;
  logic [ADDR_W-1:0] gnt_addr;
  logic              done_issue;

  // An accepted start arbitrates in the same cycle so the first fetch_en shows up one cycle later.
  assign accept   = (state == IDLE) && bus.start;
  assign base_eff = accept ? bus.base_addr : base_q;
  assign len_eff  = accept ? bus.len : len_q;
  assign ptr_eff  = accept ? '0 : ptr_q;

  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept)
        elig[c] = (bus.len != '0) && !bus.full[c];
      else if (state == RUN)
        elig[c] = (idx_q[c] != len_q) && !bus.full[c] && !inflight_q[c];
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int o = 0; o < NUM_CH; o++) begin
      if (!gnt_any && elig[(int'(ptr_eff) + o) % NUM_CH]) begin
        gnt_any = 1'b1;
        gnt_ch  = PTR_W'((int'(ptr_eff) + o) % NUM_CH);
      end
    end
    if (gnt_any) gnt[gnt_ch] = 1'b1;
  end

  always_comb begin
    idx_eff  = accept ? '0 : idx_q[gnt_ch];
    prod     = (ADDR_W+4)'(gnt_ch) * (ADDR_W+4)'(len_eff);
    gnt_addr = base_eff + prod[ADDR_W-1:0] + idx_eff;
  end

  // True when this grant takes the last word of the whole transfer.
  always_comb begin
    done_issue = gnt_any;
    for (int c = 0; c < NUM_CH; c++) begin
      if (((accept ? '0 : idx_q[c]) + ADDR_W'(gnt[c])) != len_eff) done_issue = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? DONE : (done_issue ? DRAIN : RUN);
      RUN:   if (done_issue) state_nxt = DRAIN;
      DRAIN: if (inflight_q == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      inflight_q   <= '0;
      ptr_q        <= '0;
      bus.fetch_en <= 1'b0;
      bus.addr     <= '0;
      bus.wr_en    <= '0;
      bus.busy     <= 1'b0;
      bus.all_done <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) idx_q[c] <= '0;
      for (int s = 0; s < MEM_LAT; s++) pipe_q[s] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q <= bus.base_addr;
        len_q  <= bus.len;
        ptr_q  <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept)
          idx_q[c] <= gnt[c] ? ADDR_W'(1) : '0;
        else if (gnt[c])
          idx_q[c] <= idx_q[c] + ADDR_W'(1);
      end
      if (gnt_any) ptr_q <= (gnt_ch == PTR_W'(NUM_CH - 1)) ? '0 : gnt_ch + PTR_W'(1);
      // The stage feeding wr_en releases its channel in the same cycle the write happens.
      inflight_q <= (inflight_q & ~pipe_q[MEM_LAT-1]) | gnt;
      pipe_q[0]  <= gnt;
      for (int s = 1; s < MEM_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      bus.fetch_en <= gnt_any;
      bus.addr     <= gnt_addr;
      bus.wr_en    <= pipe_q[MEM_LAT-1];
      bus.busy     <= (state_nxt == RUN) || (state_nxt == DRAIN);
      bus.all_done <= (state_nxt == DONE);
    end
  end

  assign bus.data_out = DATA_W'(bus.mem_data);
endmodule

// File: tb/tb_fetch_sched.sv
// Bench for fetch_sched: cycle tables for the directed cases, a scoreboard for randomized full patterns.
module tb_fetch_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sched_if #(.NUM_CH(4), .ADDR_W(10), .DATA_W(64)) b4 ();
  fetch_sched_if #(.NUM_CH(2), .ADDR_W(10), .DATA_W(64)) b2 ();

  fetch_sched #(.NUM_CH(4), .ADDR_W(10), .DATA_W(64), .MEM_LAT(1)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  fetch_sched #(.NUM_CH(2), .ADDR_W(10), .DATA_W(64), .MEM_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  function automatic logic [63:0] memf(input logic [9:0] a);
    return {a, 6'h00, ~a, 6'h03, a ^ 10'h155, 6'h2a, a, 6'h15};
  endfunction

  // Memories with one and two cycles of read latency.
  logic [9:0] ra4, ra2a, ra2b;
  always @(posedge clk) begin
    ra4  <= b4.addr;
    ra2a <= b2.addr;
    ra2b <= ra2a;
  end
  assign b4.mem_data = memf(ra4);
  assign b2.mem_data = memf(ra2b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic       start;
    logic [9:0] base;
    logic [9:0] len;
    logic [3:0] full;
    logic       fe;
    logic [9:0] addr;
    logic [3:0] wr;
    logic [9:0] wa;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt[$];

  // Word k of the base=0x100, len=2 transfer: channels visited 0..3, then second word of each.
  function automatic logic [9:0] s1_addr(input int k);
    return 10'h100 + 10'(((k % 4) * 2) + (k / 4));
  endfunction

  // mode 0: plain run; 1: extra start at cycle 3 (ignored); 2: reset at cycle 4.
  task automatic add_s1(input int mode);
    vec_t r;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (mode == 2 && cyc > 10) break;
      r = '{default: '0};
      r.start = (cyc == 0) || (mode == 1 && cyc == 3);
      r.base  = (cyc == 0) ? 10'h100 : ((mode == 1 && cyc == 3) ? 10'h200 : 10'h000);
      r.len   = (cyc == 0) ? 10'd2 : ((mode == 1 && cyc == 3) ? 10'd3 : 10'd0);
      r.rs    = (mode == 2 && cyc == 4);
      if (!(mode == 2 && cyc >= 5)) begin
        r.fe   = (cyc >= 1 && cyc <= 8);
        r.addr = s1_addr(cyc - 1);
        r.wr   = (cyc >= 2 && cyc <= 9) ? 4'(1 << ((cyc - 2) % 4)) : 4'h0;
        r.wa   = s1_addr(cyc - 2);
        r.busy = (cyc >= 1 && cyc <= 9);
        r.done = (cyc == 10);
      end
      vt.push_back(r);
    end
  endtask

  task automatic add_len0();
    vec_t r;
    for (int cyc = 0; cyc < 4; cyc++) begin
      r = '{default: '0};
      r.start = (cyc == 0);
      r.base  = 10'h050;
      r.done  = (cyc == 1);
      vt.push_back(r);
    end
  endtask

  task automatic run_table();
    for (int n = 0; n < vt.size(); n++) begin
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_fetch_en", n), b4.fetch_en, vt[n].fe);
      if (vt[n].fe) chk($sformatf("tbl%0d_addr", n), b4.addr, vt[n].addr);
      chk($sformatf("tbl%0d_wr_en", n), b4.wr_en, vt[n].wr);
      if (vt[n].wr != 0) chk($sformatf("tbl%0d_data", n), b4.data_out, memf(vt[n].wa));
      chk($sformatf("tbl%0d_busy", n), b4.busy, vt[n].busy);
      chk($sformatf("tbl%0d_all_done", n), b4.all_done, vt[n].done);
      rst          = vt[n].rs;
      b4.start     = vt[n].start;
      b4.base_addr = vt[n].base;
      b4.len       = vt[n].len;
      b4.full      = vt[n].full;
    end
  endtask

  // Scoreboard run on the 4-channel instance; scen2 holds full[1] through cycle 5, else random full.
  task automatic run_sb(input logic [9:0] base, input logic [9:0] len, input bit scen2);
    int nxt[4];
    bit pv[4];
    logic [9:0] pa[4];
    int pc[4];
    int nf, nw, ndone, done_cyc, last_wr, first1, c, i;
    logic [9:0] off;
    logic [3:0] fl;
    nf = 0; nw = 0; ndone = 0; done_cyc = -1; last_wr = -1; first1 = -1; fl = '0;
    for (int k = 0; k < 4; k++) begin nxt[k] = 0; pv[k] = 0; pa[k] = '0; pc[k] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (b4.fetch_en) begin
        off = b4.addr - base;
        c = int'(off) / int'(len);
        i = int'(off) % int'(len);
        chk("sb_fetch_chan", (c < 4), 1);
        if (c < 4) begin
          chk("sb_fetch_order", i, nxt[c]);
          chk("sb_one_outstanding", pv[c], 0);
          // fl still holds the full value seen at the issue decision
          chk("sb_full_respected", fl[c], 0);
          nxt[c]++;
          pv[c] = 1; pa[c] = b4.addr; pc[c] = cyc;
          if (c == 1 && first1 < 0) first1 = cyc;
        end
        nf++;
      end
      if (b4.wr_en != 0) begin
        chk("sb_wr_onehot", $countones(b4.wr_en), 1);
        c = $clog2(b4.wr_en);
        if (c < 4) begin
          chk("sb_wr_pending", pv[c], 1);
          if (pv[c]) begin
            chk("sb_wr_latency", cyc - pc[c], 1);
            chk("sb_wr_data", b4.data_out, memf(pa[c]));
            pv[c] = 0;
          end
        end
        nw++;
        last_wr = cyc;
      end
      if (b4.all_done) begin ndone++; done_cyc = cyc; end
      if (ndone > 0 && cyc >= done_cyc + 2) break;
      fl = scen2 ? ((cyc < 6) ? 4'b0010 : 4'b0000)
                 : 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      b4.full      = fl;
      b4.start     = (cyc == 0) || (ndone == 0 && $urandom_range(0, 7) == 0);
      b4.base_addr = (cyc == 0) ? base : 10'($urandom_range(0, 1023));
      b4.len       = (cyc == 0) ? len : 10'($urandom_range(0, 1023));
    end
    b4.start = 1'b0;
    b4.full  = '0;
    chk("sb_done_once", ndone, 1);
    chk("sb_fetch_count", nf, 4 * int'(len));
    chk("sb_wr_count", nw, 4 * int'(len));
    chk("sb_done_after_last_wr", done_cyc, last_wr + 1);
    for (int k = 0; k < 4; k++) chk($sformatf("sb_chan%0d_complete", k), nxt[k], len);
    if (scen2) chk("sb_ch1_not_before_6", (first1 >= 6), 1);
  endtask

  // Two channels, read latency two, address range wrapping past 0x3FF.
  task automatic run_wrap();
    logic [9:0] exp_a [4];
    logic [9:0] got [$];
    logic [9:0] pa [2];
    int pc [2];
    int ch, ndone, wrs;
    exp_a = '{10'h3FE, 10'h000, 10'h3FF, 10'h001};
    ndone = 0; wrs = 0;
    pc[0] = 0; pc[1] = 0; pa[0] = '0; pa[1] = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (b2.fetch_en) begin
        got.push_back(b2.addr);
        ch = int'(10'(b2.addr - 10'h3FE)) / 2;
        if (ch < 2) begin pc[ch] = cyc; pa[ch] = b2.addr; end
      end
      if (b2.wr_en != 0) begin
        ch = $clog2(b2.wr_en);
        wrs++;
        if (ch < 2) begin
          chk("wrap_wr_latency", cyc - pc[ch], 2);
          chk("wrap_wr_data", b2.data_out, memf(pa[ch]));
        end
      end
      if (b2.all_done) ndone++;
      b2.start     = (cyc == 0);
      b2.base_addr = 10'h3FE;
      b2.len       = 10'd2;
    end
    chk("wrap_fetch_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) chk($sformatf("wrap_addr%0d", k), got[k], exp_a[k]);
    chk("wrap_wr_count", wrs, 4);
    chk("wrap_done_once", ndone, 1);
  endtask

  initial begin
    rst = 1'b1;
    b4.start = 1'b0; b4.base_addr = '0; b4.len = '0; b4.full = '0;
    b2.start = 1'b0; b2.base_addr = '0; b2.len = '0; b2.full = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fetch_en", b4.fetch_en, 0);
    chk("reset_addr", b4.addr, 0);
    chk("reset_wr_en", b4.wr_en, 0);
    chk("reset_busy", b4.busy, 0);
    chk("reset_all_done", b4.all_done, 0);
    chk("reset_busy_2ch", b2.busy, 0);

    add_s1(0);
    add_s1(1);
    add_s1(2);
    add_s1(0);
    add_len0();
    run_table();

    run_sb(10'h100, 10'd2, 1'b1);
    for (int r = 0; r < 25; r++)
      run_sb(10'($urandom_range(0, 1023)), 10'($urandom_range(1, 8)), 1'b0);

    run_wrap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
